// File: rtl/mem_word_master.sv
// Byte-serial memory master: turns 32-bit word or single-byte load/store
// requests into 1 or 4 one-cycle byte beats on an 8-bit memory port,
// little-endian, then reports completion with a one-cycle rsp_valid pulse.
module mem_word_master #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             req_valid,
  output logic             req_ready,
  input  logic             req_write,
  input  logic             req_word,
  input  logic [WIDTH-1:0] req_adr,
  input  logic [31:0]      req_wdata,
  output logic             rsp_valid,
  output logic [31:0]      rsp_rdata,
  output logic             memwrite,
  output logic [WIDTH-1:0] adr,
  output logic [7:0]       writedata,
  input  logic [7:0]       memdata
);

  typedef enum logic [1:0] {IDLE, XFER, DONE} state_t;

  state_t           state_reg, state_next;
  logic [1:0]       cnt_reg, cnt_next;
  logic             write_reg;
  logic             word_reg;
  logic [WIDTH-1:0] adr_reg;
  logic [31:0]      wdata_reg;
  logic [31:0]      acc_reg;     // load bytes gathered so far
  logic [31:0]      rdata_reg;   // last completed load result
  logic [31:0]      acc_next;
  logic [31:0]      merged;
  logic [7:0]       wbyte [4];
  logic             last_beat;
  logic             accept;

  // Per-lane views: store byte for each lane, and the accumulator with the
  // current beat's memory byte dropped into its lane.
  generate
    for (genvar gi = 0; gi < 4; gi++) begin : g_lane
      assign wbyte[gi] = wdata_reg[8*gi +: 8];
      assign merged[8*gi +: 8] = (cnt_reg == 2'(gi)) ? memdata : acc_reg[8*gi +: 8];
    end
  endgenerate

  assign last_beat = word_reg ? (cnt_reg == 2'd3) : 1'b1;
  // Byte loads zero-extend; word loads fill lane cnt.
  assign acc_next  = word_reg ? merged : {24'h0, memdata};
  assign accept    = req_valid && req_ready;
  assign rsp_rdata = rdata_reg;

  // State, beat counter, request capture and load-data assembly.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_reg <= IDLE;
      cnt_reg   <= 2'd0;
      write_reg <= 1'b0;
      word_reg  <= 1'b0;
      adr_reg   <= '0;
      wdata_reg <= 32'h0;
      acc_reg   <= 32'h0;
      rdata_reg <= 32'h0;
    end else begin
      state_reg <= state_next;
      cnt_reg   <= cnt_next;
      if (accept) begin
        write_reg <= req_write;
        word_reg  <= req_word;
        adr_reg   <= req_adr;
        wdata_reg <= req_wdata;
      end
      // Result is published only when the load's final beat completes, so
      // rsp_rdata stays stable through stores and through a load in flight.
      if (state_reg == XFER && !write_reg) begin
        acc_reg <= acc_next;
        if (last_beat) rdata_reg <= acc_next;
      end
    end
  end

  // Next-state and memory-port / handshake outputs; everything is gated
  // off while reset is high.
  always_comb begin
    state_next = state_reg;
    cnt_next   = cnt_reg;
    req_ready  = 1'b0;
    rsp_valid  = 1'b0;
    memwrite   = 1'b0;
    adr        = '0;
    writedata  = 8'h0;
    case (state_reg)
      IDLE: begin
        req_ready = !reset;
        if (req_valid && !reset) begin
          state_next = XFER;
          cnt_next   = 2'd0;
        end
      end
      XFER: begin
        if (!reset) begin
          memwrite  = write_reg;
          adr       = word_reg ? {adr_reg[WIDTH-1:2], cnt_reg} : adr_reg;
          writedata = write_reg ? wbyte[cnt_reg] : 8'h0;
        end
        if (last_beat) state_next = DONE;
        else           cnt_next   = cnt_reg + 2'd1;
      end
      DONE: begin
        rsp_valid  = !reset;
        state_next = IDLE;
      end
      default: state_next = IDLE;
    endcase
  end

endmodule

// File: tb/tb_mem_word_master.sv
// Directed bench for mem_word_master with a 256-byte memory model.
module tb_mem_word_master;

  logic        clk = 1'b0;
  logic        reset;
  logic        req_valid, req_ready, req_write, req_word;
  logic [7:0]  req_adr;
  logic [31:0] req_wdata;
  logic        rsp_valid;
  logic [31:0] rsp_rdata;
  logic        memwrite;
  logic [7:0]  adr, writedata, memdata;

  logic [7:0]  mem [256];
  int          checks = 0;
  int          errors = 0;

  always #5 clk = ~clk;

  mem_word_master #(.WIDTH(8)) dut (
    .clk(clk), .reset(reset),
    .req_valid(req_valid), .req_ready(req_ready),
    .req_write(req_write), .req_word(req_word),
    .req_adr(req_adr), .req_wdata(req_wdata),
    .rsp_valid(rsp_valid), .rsp_rdata(rsp_rdata),
    .memwrite(memwrite), .adr(adr), .writedata(writedata),
    .memdata(memdata)
  );

  assign memdata = mem[adr];
  always @(posedge clk) if (memwrite) mem[adr] <= writedata;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %08h expected %08h", tag, got, exp);
    end
  endtask

  // advance one cycle and land 1 time unit after the rising edge
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // One full transaction with per-beat and completion checks.
  task automatic run_txn(input string name, input logic wr, input logic wd,
                         input logic [7:0] a, input logic [31:0] data,
                         input logic [31:0] exp_rdata);
    int n;
    logic [7:0] ea;
    n = wd ? 4 : 1;
    check({name, " ready"}, 32'(req_ready), 32'd1);
    req_valid = 1'b1; req_write = wr; req_word = wd; req_adr = a; req_wdata = data;
    step();
    // scramble inputs: must be ignored after accept
    req_valid = 1'b0; req_adr = 8'h55; req_wdata = 32'hFFFFFFFF; req_write = ~wr;
    for (int k = 0; k < n; k++) begin
      ea = wd ? {a[7:2], 2'(k)} : a;
      check($sformatf("%s beat%0d adr", name, k), 32'(adr), 32'(ea));
      check($sformatf("%s beat%0d memwrite", name, k), 32'(memwrite), 32'(wr));
      check($sformatf("%s beat%0d wdata", name, k), 32'(writedata),
            wr ? 32'(data[8*k +: 8]) : 32'd0);
      check($sformatf("%s beat%0d rsp_valid", name, k), 32'(rsp_valid), 32'd0);
      step();
    end
    check({name, " rsp_valid"}, 32'(rsp_valid), 32'd1);
    check({name, " rdata"}, rsp_rdata, exp_rdata);
    check({name, " adr idle"}, 32'(adr), 32'd0);
    step();
    check({name, " rsp_valid off"}, 32'(rsp_valid), 32'd0);
    check({name, " ready again"}, 32'(req_ready), 32'd1);
    check({name, " rdata held"}, rsp_rdata, exp_rdata);
    $display("txn %s wr=%0d word=%0d adr=%02h rdata=%08h", name, wr, wd, a, rsp_rdata);
  endtask

  initial begin
    int accepts, first_rsp, second_rsp, rsps;
    logic saw_write;
    for (int i = 0; i < 256; i++) mem[i] = 8'h00;
    mem[12] = 8'hEF; mem[13] = 8'hBE; mem[14] = 8'hAD; mem[15] = 8'hDE;
    mem[8'h40] = 8'h11; mem[8'h41] = 8'h22; mem[8'h42] = 8'h33; mem[8'h43] = 8'h44;
    mem[8'hFC] = 8'h01; mem[8'hFD] = 8'h02; mem[8'hFE] = 8'h03; mem[8'hFF] = 8'h04;
    reset = 1'b1; req_valid = 1'b0; req_write = 1'b0; req_word = 1'b0;
    req_adr = 8'h0; req_wdata = 32'h0;

    // reset held two cycles, all outputs low
    for (int c = 0; c < 2; c++) begin
      step();
      check("rst ready", 32'(req_ready), 32'd0);
      check("rst rsp_valid", 32'(rsp_valid), 32'd0);
      check("rst rdata", rsp_rdata, 32'd0);
      check("rst memwrite", 32'(memwrite), 32'd0);
      check("rst adr", 32'(adr), 32'd0);
      check("rst writedata", 32'(writedata), 32'd0);
    end
    reset = 1'b0;
    #1;
    check("post-reset ready", 32'(req_ready), 32'd1);
    $display("txn reset released ready=%0d", req_ready);

    run_txn("wload0E", 1'b0, 1'b1, 8'h0E, 32'h0, 32'hDEADBEEF);
    run_txn("bload0D", 1'b0, 1'b0, 8'h0D, 32'h0, 32'h000000BE);
    // store leaves previous load result in place
    run_txn("wstore20", 1'b1, 1'b1, 8'h20, 32'h12345678, 32'h000000BE);
    check("mem20", 32'(mem[8'h20]), 32'h78);
    check("mem23", 32'(mem[8'h23]), 32'h12);
    run_txn("wload20", 1'b0, 1'b1, 8'h20, 32'h0, 32'h12345678);
    run_txn("bstore21", 1'b1, 1'b0, 8'h21, 32'hFFFFFF9A, 32'h12345678);
    check("mem21 byte", 32'(mem[8'h21]), 32'h9A);
    check("mem22 kept", 32'(mem[8'h22]), 32'h34);
    run_txn("wloadFF", 1'b0, 1'b1, 8'hFF, 32'h0, 32'h04030201);
    run_txn("bloadFF", 1'b0, 1'b0, 8'hFF, 32'h0, 32'h00000004);

    // reset during the third beat of a word store
    req_valid = 1'b1; req_write = 1'b1; req_word = 1'b1;
    req_adr = 8'h40; req_wdata = 32'hAABBCCDD;
    step();
    req_valid = 1'b0;
    check("abort beat0 adr", 32'(adr), 32'h40);
    step();
    check("abort beat1 adr", 32'(adr), 32'h41);
    step();
    check("abort beat2 adr", 32'(adr), 32'h42);
    reset = 1'b1;
    #1;
    check("abort rst memwrite", 32'(memwrite), 32'd0);
    check("abort rst adr", 32'(adr), 32'd0);
    step();
    reset = 1'b0;
    #1;
    check("abort ready", 32'(req_ready), 32'd1);
    rsps = 0;
    for (int c = 0; c < 5; c++) begin
      if (rsp_valid) rsps++;
      if (memwrite) rsps++;
      step();
    end
    check("abort no activity", 32'(rsps), 32'd0);
    check("abort rdata", rsp_rdata, 32'd0);
    check("mem40", 32'(mem[8'h40]), 32'hDD);
    check("mem41", 32'(mem[8'h41]), 32'hCC);
    check("mem42", 32'(mem[8'h42]), 32'h33);
    check("mem43", 32'(mem[8'h43]), 32'h44);
    $display("txn abort mem40..43=%02h %02h %02h %02h",
             mem[8'h40], mem[8'h41], mem[8'h42], mem[8'h43]);

    // req_valid held high for 12 cycles
    accepts = 0; first_rsp = -1; second_rsp = -1; saw_write = 1'b0;
    req_valid = 1'b1; req_write = 1'b0; req_word = 1'b1; req_adr = 8'h0C;
    for (int c = 0; c < 12; c++) begin
      if (req_valid && req_ready) accepts++;
      if (rsp_valid) begin
        if (first_rsp < 0) first_rsp = c;
        else second_rsp = c;
      end
      if (memwrite) saw_write = 1'b1;
      step();
    end
    req_valid = 1'b0;
    check("held accepts", 32'(accepts), 32'd2);
    check("held rsp spacing", 32'(second_rsp - first_rsp), 32'd6);
    check("held first rsp", 32'(first_rsp), 32'd5);
    check("held no write", 32'(saw_write), 32'd0);
    check("held rdata", rsp_rdata, 32'hDEADBEEF);
    $display("txn held accepts=%0d rsp at %0d,%0d", accepts, first_rsp, second_rsp);

    step();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
